// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO widths, pointer types and pointer-empty compare
package fifo_pkg;

    localparam int FIFO_ALEN = 8;
    localparam int FIFO_DLEN = 8;
    localparam int FIFO_INCR = 1;

    typedef logic [FIFO_ALEN:0]   ptr_t;
    typedef logic [FIFO_ALEN-1:0] addr_t;
    typedef logic [FIFO_DLEN-1:0] data_t;

    // Full-width compare: the extra MSB separates "empty" from "full" at equal addresses.
    function automatic logic ptr_empty(input ptr_t rptr, input ptr_t wptr);
        return (rptr == wptr);
    endfunction

endpackage

// File: rtl/axis_out_buf.sv
// rtl/axis_out_buf.sv - 2-entry AXI-stream output buffer fed by RAM read data
module axis_out_buf #(
    parameter int DLEN = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_wen,
    input  logic [DLEN-1:0] i_wdata,
    input  logic            i_tready,
    output logic            o_tvalid,
    output logic [DLEN-1:0] o_tdata,
    output logic [1:0]      o_cnt
);

    logic [DLEN-1:0] head;
    logic [DLEN-1:0] tail;
    logic [1:0]      cnt;
    logic            pop;

    assign pop      = o_tvalid & i_tready;
    assign o_tvalid = (cnt != 2'd0);
    assign o_tdata  = head;
    assign o_cnt    = cnt;

    // Head only changes when it is empty or being popped, which keeps tdata stable under backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head <= '0;
            tail <= '0;
            cnt  <= 2'd0;
        end else begin
            case ({i_wen, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= i_wdata;
                    else             tail <= i_wdata;
                end
                2'b01: begin
                    if (cnt == 2'd2) head <= tail;
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        head <= tail;
                        tail <= i_wdata;
                    end else begin
                        head <= i_wdata;
                    end
                end
                default: ;
            endcase
            cnt <= cnt + {1'b0, i_wen} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (!(i_wen && !pop && (cnt == 2'd2)));
        end
    end

endmodule

// File: rtl/rd_ptr_axis.sv
// rtl/rd_ptr_axis.sv - FIFO read pointer, empty detect and RAM read issue into an AXI-stream master
module rd_ptr_axis
    import fifo_pkg::*;
#(
    parameter int ALEN = FIFO_ALEN,
    parameter int INCR = FIFO_INCR,
    parameter int DLEN = FIFO_DLEN
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [ALEN:0]   i_wptr,
    output logic [ALEN:0]   o_rptr,
    output logic            o_rempty,
    output logic [ALEN-1:0] o_raddr,
    output logic            o_ram_ren,
    input  logic [DLEN-1:0] i_ram_rdata,
    output logic            o_tvalid,
    input  logic            i_tready,
    output logic [DLEN-1:0] o_tdata
);

    localparam logic [ALEN:0] INCR_P = (ALEN+1)'(INCR);

    logic [ALEN:0] rptr;
    logic          inflight;
    logic [1:0]    buf_cnt;
    logic [2:0]    occ;
    logic          pop;

    generate
        if (ALEN == FIFO_ALEN) begin : g_pkg_cmp
            assign o_rempty = ptr_empty(rptr, i_wptr);
        end else begin : g_cmp
            assign o_rempty = (rptr == i_wptr);
        end
    endgenerate

    assign pop       = o_tvalid & i_tready;
    assign occ       = {1'b0, buf_cnt} + {2'b0, inflight};
    // A read may be issued into a full buffer only when a pop frees a slot in the same cycle.
    assign o_ram_ren = !o_rempty && ((occ < 3'd2) || pop);
    assign o_rptr    = rptr;
    assign o_raddr   = rptr[ALEN-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= o_ram_ren;
            if (o_ram_ren) rptr <= rptr + INCR_P;
        end
    end

    axis_out_buf #(
        .DLEN(DLEN)
    ) u_out_buf (
        .clk      (clk),
        .rstn     (rstn),
        .i_wen    (inflight),
        .i_wdata  (i_ram_rdata),
        .i_tready (i_tready),
        .o_tvalid (o_tvalid),
        .o_tdata  (o_tdata),
        .o_cnt    (buf_cnt)
    );

endmodule

// File: tb/tb_rd_ptr_axis.sv
// tb/tb_rd_ptr_axis.sv - self-checking bench for rd_ptr_axis with RAM model and beat scoreboard
module tb_rd_ptr_axis;

    logic       clk = 1'b0;
    logic       rstn;
    logic [8:0] wptr;
    logic [8:0] rptr;
    logic       rempty;
    logic [7:0] raddr;
    logic       ren;
    logic [7:0] rdata = 8'h00;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;

    logic [7:0] ram [0:255];
    logic [7:0] exp_q [$];
    logic [7:0] mon_exp;
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ren) rdata <= ram[raddr];

    rd_ptr_axis #(.ALEN(8), .INCR(1), .DLEN(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_wptr      (wptr),
        .o_rptr      (rptr),
        .o_rempty    (rempty),
        .o_raddr     (raddr),
        .o_ram_ren   (ren),
        .i_ram_rdata (rdata),
        .o_tvalid    (tvalid),
        .i_tready    (tready),
        .o_tdata     (tdata)
    );

    always @(negedge clk) begin
        if (rstn === 1'b1 && tvalid === 1'b1 && tready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got beat %h, expected no beat", tdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tdata !== mon_exp) begin
                    n_fail++;
                    $display("FAIL beat_data: got %h expected %h", tdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000ns, expected finish");
        $fatal(1);
    end

    task automatic do_reset();
        rstn = 1'b0;
        wptr = 9'h000;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; wptr = 9'h000; tready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_checks++; if (rptr !== 9'h000)  begin n_fail++; $display("FAIL reset_rptr: got %h expected 000", rptr); end
        n_checks++; if (rempty !== 1'b1)  begin n_fail++; $display("FAIL reset_rempty: got %b expected 1", rempty); end
        n_checks++; if (ren !== 1'b0)     begin n_fail++; $display("FAIL reset_ren: got %b expected 0", ren); end
        n_checks++; if (tvalid !== 1'b0)  begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", tvalid); end
        n_checks++; if (tdata !== 8'h00)  begin n_fail++; $display("FAIL reset_tdata: got %h expected 00", tdata); end
        wptr = 9'h005;
        #1;
        n_checks++; if (rempty !== 1'b0)  begin n_fail++; $display("FAIL reset_rempty_follow: got %b expected 0", rempty); end
        wptr = 9'h000;
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        ram[0] = 8'hA5;
        tready = 1'b1;
        @(posedge clk);
        #1 wptr = 9'h001;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        n_checks++; if (ren !== 1'b1)     begin n_fail++; $display("FAIL single_ren_n: got %b expected 1", ren); end
        n_checks++; if (raddr !== 8'h00)  begin n_fail++; $display("FAIL single_raddr: got %h expected 00", raddr); end
        @(negedge clk);
        n_checks++; if (ren !== 1'b0)     begin n_fail++; $display("FAIL single_ren_n1: got %b expected 0", ren); end
        n_checks++; if (rptr !== 9'h001)  begin n_fail++; $display("FAIL single_rptr: got %h expected 001", rptr); end
        n_checks++; if (tvalid !== 1'b0)  begin n_fail++; $display("FAIL single_tvalid_early: got %b expected 0", tvalid); end
        @(negedge clk);
        n_checks++; if (tvalid !== 1'b1)  begin n_fail++; $display("FAIL single_tvalid: got %b expected 1", tvalid); end
        @(negedge clk);
        n_checks++; if (tvalid !== 1'b0)  begin n_fail++; $display("FAIL single_tvalid_after: got %b expected 0", tvalid); end
        n_checks++; if (rempty !== 1'b1)  begin n_fail++; $display("FAIL single_rempty: got %b expected 1", rempty); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_pending: got %0d expected 0", exp_q.size()); end
        ram[0] = 8'h00;
    endtask

    task automatic test_backpressure();
        int reads = 0, addr_bad = 0, stab_bad = 0, beats = 0;
        bit seen = 0;
        do_reset();
        tready = 1'b0;
        @(posedge clk);
        #1 wptr = 9'h004;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(k));
        repeat (8) begin
            @(negedge clk);
            if (ren === 1'b1) begin
                if (raddr !== 8'(reads)) addr_bad++;
                reads++;
            end
            if (tvalid === 1'b1) seen = 1;
            if (seen && (tvalid !== 1'b1 || tdata !== 8'h00)) stab_bad++;
        end
        n_checks++; if (reads != 2)       begin n_fail++; $display("FAIL bp_reads: got %0d expected 2", reads); end
        n_checks++; if (addr_bad != 0)    begin n_fail++; $display("FAIL bp_raddr: got %0d bad addresses expected 0", addr_bad); end
        n_checks++; if (rptr !== 9'h002)  begin n_fail++; $display("FAIL bp_rptr: got %h expected 002", rptr); end
        n_checks++; if (!seen || stab_bad != 0) begin n_fail++; $display("FAIL bp_stable: got seen=%0d unstable=%0d expected seen=1 unstable=0", seen, stab_bad); end
        @(posedge clk);
        #1 tready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (tvalid === 1'b1) beats++;
        end
        n_checks++; if (beats != 4)       begin n_fail++; $display("FAIL bp_consecutive: got %0d beats in 4 cycles expected 4", beats); end
        @(negedge clk);
        n_checks++; if (tvalid !== 1'b0)  begin n_fail++; $display("FAIL bp_tvalid_end: got %b expected 0", tvalid); end
        n_checks++; if (rptr !== 9'h004)  begin n_fail++; $display("FAIL bp_rptr_end: got %h expected 004", rptr); end
        n_checks++; if (rempty !== 1'b1)  begin n_fail++; $display("FAIL bp_rempty_end: got %b expected 1", rempty); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_throughput();
        int first = -1, last = -1, beats = 0;
        do_reset();
        tready = 1'b1;
        @(posedge clk);
        #1 wptr = 9'h010;
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (tvalid === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                beats++;
            end
        end
        n_checks++; if (first != 2)  begin n_fail++; $display("FAIL tp_first: got cycle %0d expected 2", first); end
        n_checks++; if (beats != 16) begin n_fail++; $display("FAIL tp_beats: got %0d expected 16", beats); end
        n_checks++; if (last != 17)  begin n_fail++; $display("FAIL tp_last: got cycle %0d expected 17", last); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL tp_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        int reads = 0, addr_bad = 0, empty_bad = 0;
        do_reset();
        tready = 1'b1;
        @(posedge clk);
        #1 wptr = 9'h100;
        for (int k = 0; k < 256; k++) exp_q.push_back(8'(k));
        @(negedge clk);
        n_checks++; if (rempty !== 1'b0) begin n_fail++; $display("FAIL wrap_full_not_empty: got %b expected 0", rempty); end
        if (ren === 1'b1) reads++;
        repeat (299) begin
            @(negedge clk);
            if (ren === 1'b1) reads++;
        end
        n_checks++; if (reads != 256)    begin n_fail++; $display("FAIL wrap_full_reads: got %0d expected 256", reads); end
        n_checks++; if (rptr !== 9'h100) begin n_fail++; $display("FAIL wrap_rptr_100: got %h expected 100", rptr); end
        n_checks++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL wrap_rempty_100: got %b expected 1", rempty); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_pending_a: got %0d expected 0", exp_q.size()); end
        @(posedge clk);
        #1 wptr = 9'h180;
        for (int k = 0; k < 128; k++) exp_q.push_back(8'(k));
        reads = 0;
        repeat (160) begin
            @(negedge clk);
            if ((rptr !== 9'h180) && (rempty !== 1'b0)) empty_bad++;
            if ((rptr === 9'h180) && (rempty !== 1'b1)) empty_bad++;
            if (ren === 1'b1) begin
                if (raddr !== 8'(reads)) addr_bad++;
                reads++;
            end
        end
        n_checks++; if (reads != 128)    begin n_fail++; $display("FAIL wrap_reads: got %0d expected 128", reads); end
        n_checks++; if (addr_bad != 0)   begin n_fail++; $display("FAIL wrap_raddr: got %0d bad addresses expected 0", addr_bad); end
        n_checks++; if (empty_bad != 0)  begin n_fail++; $display("FAIL wrap_rempty: got %0d bad cycles expected 0", empty_bad); end
        n_checks++; if (rptr !== 9'h180) begin n_fail++; $display("FAIL wrap_rptr_180: got %h expected 180", rptr); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_pending_b: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int beats = 0, rens = 0;
        do_reset();
        tready = 1'b0;
        @(posedge clk);
        #1 wptr = 9'h002;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        repeat (4) @(negedge clk);
        n_checks++; if (tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_tvalid_before: got %b expected 1", tvalid); end
        #2 rstn = 1'b0;
        #1;
        n_checks++; if (tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid_async: got %b expected 0", tvalid); end
        n_checks++; if (rptr !== 9'h000) begin n_fail++; $display("FAIL mid_rptr_async: got %h expected 000", rptr); end
        exp_q.delete();
        wptr = 9'h000;
        tready = 1'b1;
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (tvalid === 1'b1) beats++;
            if (ren === 1'b1) rens++;
        end
        n_checks++; if (beats != 0 || rens != 0) begin n_fail++; $display("FAIL mid_idle: got beats=%0d reads=%0d expected 0 0", beats, rens); end
        @(posedge clk);
        #1 wptr = 9'h001;
        exp_q.push_back(ram[0]);
        beats = 0;
        repeat (5) begin
            @(negedge clk);
            if (tvalid === 1'b1) beats++;
        end
        n_checks++; if (beats != 1) begin n_fail++; $display("FAIL mid_resume: got %0d beats expected 1", beats); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_pending: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ram[k] = 8'(k);
        rstn = 1'b0;
        wptr = 9'h000;
        tready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_throughput();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rd_ptr_axis.md
Name: rd_ptr_axis

Overview:
Read-side controller for the synchronous AXI-stream FIFO, paired with the write-pointer block.
- Owns the binary read pointer and exports it to the write side for full detection.
- Computes empty from the incoming write pointer.
- Issues reads to the dual-port RAM, which has 1-cycle read latency.
- Presents data as an AXI-stream master through a 2-entry output buffer, sustaining one beat per cycle under continuous tready.

Parameters:
ALEN, 8, RAM address width; FIFO RAM depth 2**ALEN; pointers are ALEN+1 bits.
INCR, 1, pointer increment per RAM read; must divide 2**ALEN.
DLEN, 8, data width of RAM read port and o_tdata.

Ports:
clk  in  1  clock; all logic on posedge.
rstn  in  1  asynchronous active-low reset.
i_wptr  in  ALEN+1  binary write pointer from the write-pointer block (registered there).
o_rptr  out  ALEN+1  binary read pointer to the write-pointer block.
o_rempty  out  1  high when o_rptr == i_wptr (all ALEN+1 bits).
o_raddr  out  ALEN  RAM read address = o_rptr[ALEN-1:0].
o_ram_ren  out  1  RAM read enable.
i_ram_rdata  in  DLEN  RAM read data, valid the cycle after o_ram_ren.
o_tvalid  out  1  AXI-stream valid.
i_tready  in  1  AXI-stream ready.
o_tdata  out  DLEN  AXI-stream data.

Behaviour:
- Reset (async assert, sync release):
  - rptr=0, buffer count=0, in-flight flag=0, both buffer entries=0.
  - Resulting outputs: o_tvalid=0, o_tdata=0, o_ram_ren=0.
  - o_rempty follows i_wptr.
  - Mid-operation reset discards buffered and in-flight data immediately.
- Definitions:
  - pop = o_tvalid & i_tready.
  - occ = buf_cnt + inflight, always in 0..2.
- Read issue, combinational: o_ram_ren = !o_rempty & ((occ < 2) | pop).
- On each ren edge:
  - rptr <= rptr + INCR, modulo 2**(ALEN+1).
  - inflight <= 1.
- Without ren, inflight <= 0.
- Data capture:
  - When inflight=1, i_ram_rdata is written into the buffer at the tail.
  - If the buffer is empty, or holds one entry that is popped in the same cycle, the data goes directly to the head entry.
- Buffer update per edge: buf_cnt += inflight - pop.
  - Simultaneous capture and pop is legal.
  - Overflow is impossible by the ren rule and is asserted in simulation.
- AXI rules:
  - o_tvalid = (buf_cnt != 0).
  - o_tdata = head entry.
  - While o_tvalid & !i_tready, o_tdata and o_tvalid stay stable.
  - No combinational path from i_tready to o_tvalid.
- Latency: if i_wptr changes at edge N on an empty FIFO, then:
  - o_ram_ren is high in cycle N.
  - rptr advances at edge N+1.
  - o_tvalid rises after edge N+2 with the RAM word.
- Throughput: with i_tready=1 and a non-empty FIFO, one beat per cycle and no bubbles.
- o_rptr counts words fetched, not words popped.
  - RAM slots are freed at fetch time.
  - Total storage = 2**ALEN + 2 words.
- Wrap-around:
  - rptr MSB toggles when the address wraps from 2**ALEN-INCR to 0.
  - o_rempty requires equality including the MSB.
  - i_wptr = rptr ^ (1<<ALEN) means the RAM is full, not empty.

Decomposition:
- Package fifo_pkg, shared with the write-pointer block:
  - default ALEN, DLEN, INCR.
  - ptr_t (ALEN+1 bits), addr_t (ALEN bits), data_t (DLEN bits).
  - function ptr_empty(rptr, wptr).
- One sub-module, axis_out_buf: the 2-entry buffer with the capture/pop/count logic and the AXI stability guarantee.
- rd_ptr_axis keeps the pointer, empty compare, ren rule and inflight flag.

Test Plan:
1. Reset: rstn low 10 cycles, i_wptr=0 -> o_rptr=0x000, o_rempty=1, o_ram_ren=0, o_tvalid=0, o_tdata=0x00.
2. Single word: RAM[0]=0xA5, i_wptr 0x000->0x001 at edge N, i_tready=1 -> o_ram_ren high one cycle with o_raddr=0x00; o_rptr=0x001 after N+1; o_tvalid high exactly one cycle after N+2 with o_tdata=0xA5; then o_rempty=1.
3. Backpressure: RAM[k]=k, i_wptr=0x004, i_tready=0 -> exactly two reads (addr 0x00, 0x01); o_rptr=0x002; o_tdata=0x00 held stable. Raise i_tready -> beats 0x00,0x01,0x02,0x03 on consecutive cycles; final o_rptr=0x004, o_rempty=1.
4. Throughput: i_wptr=0x010, i_tready=1 throughout -> 16 beats on 16 consecutive cycles starting 2 cycles after the wptr change; data 0x00..0x0F in order.
5. Wrap: drain 256 words so rptr=0x100, set i_wptr=0x180 -> o_raddr runs 0x00..0x7F, o_rempty=0 until o_rptr=0x180. Separately, rptr=0x000 with i_wptr=0x100 -> o_rempty=0 and 256 reads.
6. Reset mid-stream: two words buffered, i_tready=0, rstn pulled low between edges -> o_tvalid=0 and o_rptr=0x000 immediately (asynchronous); no beats after release until i_wptr differs from 0x000.
